// File: rtl/env_sensor_conditioner.sv
// env_sensor_conditioner
//   Conditions a strobed environmental sensor stream: 4-tap moving average on
//   wind and temperature, debounced visibility code, held thunderstorm flag,
//   and a sample-stream timeout that drives a fail-safe fault state.
// Ports:
//   CLK, RST         rising-edge clock, asynchronous active-high reset
//   sample_valid     one-cycle strobe qualifying the raw_* inputs
//   raw_wind         unsigned raw wind (6 bit)
//   raw_visibility   raw visibility code (2 bit)
//   raw_temperature  signed raw temperature (8 bit)
//   raw_lightning    lightning seen in this sample
//   wind             filtered wind
//   visibility       debounced visibility code
//   temperature      signed filtered temperature
//   thunderstorm     held storm flag, forced high while faulted
//   data_valid       one-cycle pulse when outputs update from a sample
//   sensor_fault     sample stream timed out
module env_sensor_conditioner #(
   parameter int unsigned TIMEOUT    = 100,
   parameter int unsigned STORM_HOLD = 8,
   parameter int unsigned VIS_STABLE = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       sample_valid,
   input  logic [5:0] raw_wind,
   input  logic [1:0] raw_visibility,
   input  logic [7:0] raw_temperature,
   input  logic       raw_lightning,
   output logic [5:0] wind,
   output logic [1:0] visibility,
   output logic [7:0] temperature,
   output logic       thunderstorm,
   output logic       data_valid,
   output logic       sensor_fault
);

   localparam int unsigned IW = $clog2(TIMEOUT + 1);
   localparam int unsigned SW = $clog2(STORM_HOLD + 1);
   localparam int unsigned VW = $clog2(VIS_STABLE + 1);
   localparam logic [IW-1:0] TimeoutC = IW'(TIMEOUT);
   localparam logic [SW-1:0] StormC   = SW'(STORM_HOLD);
   localparam logic [VW-1:0] VisC     = VW'(VIS_STABLE);

   localparam logic [1:0] StInit  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StFault = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [5:0]    wind_hist_q [4];
   logic [5:0]    wind_hist_d [4];
   logic [7:0]    temp_hist_q [4];
   logic [7:0]    temp_hist_d [4];
   logic [1:0]    vis_cand_q, vis_cand_d;
   logic [VW-1:0] vis_cnt_q, vis_cnt_d;
   logic          storm_flag_q, storm_flag_d;
   logic [SW-1:0] storm_cnt_q, storm_cnt_d;

   logic [5:0] wind_q, wind_d;
   logic [1:0] vis_q, vis_d;
   logic [7:0] temp_q, temp_d;
   logic       thunder_q, thunder_d;
   logic       data_valid_q, data_valid_d;
   logic       fault_q, fault_d;

   logic [7:0]        wind_sum;
   logic signed [9:0] temp_sum;

   always_comb begin
      state_d      = state_q;
      idle_d       = idle_q;
      wind_hist_d  = wind_hist_q;
      temp_hist_d  = temp_hist_q;
      vis_d        = vis_q;
      vis_cand_d   = vis_cand_q;
      vis_cnt_d    = vis_cnt_q;
      storm_flag_d = storm_flag_q;
      storm_cnt_d  = storm_cnt_q;
      data_valid_d = 1'b0;

      if (!sample_valid && (idle_q < TimeoutC)) begin
         idle_d = idle_q + 1'b1;
      end

      if (sample_valid) begin
         // A sample always wins over a timeout landing on the same edge.
         idle_d       = '0;
         state_d      = StRun;
         data_valid_d = 1'b1;

         if (state_q != StRun) begin
            // Prime: fill the whole history so the average starts at the sample.
            for (int i = 0; i < 4; i++) begin
               wind_hist_d[i] = raw_wind;
               temp_hist_d[i] = raw_temperature;
            end
            vis_d      = raw_visibility;
            vis_cand_d = raw_visibility;
            vis_cnt_d  = VW'(1);
         end else begin
            for (int i = 3; i > 0; i--) begin
               wind_hist_d[i] = wind_hist_q[i-1];
               temp_hist_d[i] = temp_hist_q[i-1];
            end
            wind_hist_d[0] = raw_wind;
            temp_hist_d[0] = raw_temperature;

            if (raw_visibility == vis_cand_q) begin
               if (vis_cnt_q < VisC) vis_cnt_d = vis_cnt_q + 1'b1;
            end else begin
               vis_cand_d = raw_visibility;
               vis_cnt_d  = VW'(1);
            end
            if (vis_cnt_d >= VisC) vis_d = vis_cand_d;
         end

         if (raw_lightning) begin
            storm_flag_d = 1'b1;
            storm_cnt_d  = StormC;
         end else if (storm_cnt_q != '0) begin
            storm_cnt_d = storm_cnt_q - 1'b1;
            if (storm_cnt_d == '0) storm_flag_d = 1'b0;
         end
      end else if ((state_q != StFault) && (idle_d == TimeoutC)) begin
         state_d = StFault;
      end

      fault_d   = (state_d == StFault);
      thunder_d = fault_d | storm_flag_d;
   end

   // Averages are taken over the post-update history so they land with the sample.
   always_comb begin
      wind_sum = {2'b00, wind_hist_d[0]} + {2'b00, wind_hist_d[1]}
               + {2'b00, wind_hist_d[2]} + {2'b00, wind_hist_d[3]};
      temp_sum = {{2{temp_hist_d[0][7]}}, temp_hist_d[0]} + {{2{temp_hist_d[1][7]}}, temp_hist_d[1]}
               + {{2{temp_hist_d[2][7]}}, temp_hist_d[2]} + {{2{temp_hist_d[3][7]}}, temp_hist_d[3]};
      wind_d = wind_q;
      temp_d = temp_q;
      if (sample_valid) begin
         wind_d = 6'(wind_sum >> 2);
         temp_d = 8'(temp_sum >>> 2);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StInit;
         idle_q       <= '0;
         for (int i = 0; i < 4; i++) begin
            wind_hist_q[i] <= '0;
            temp_hist_q[i] <= '0;
         end
         vis_cand_q   <= '0;
         vis_cnt_q    <= '0;
         storm_flag_q <= 1'b0;
         storm_cnt_q  <= '0;
         wind_q       <= '0;
         vis_q        <= '0;
         temp_q       <= '0;
         thunder_q    <= 1'b0;
         data_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         wind_hist_q  <= wind_hist_d;
         temp_hist_q  <= temp_hist_d;
         vis_cand_q   <= vis_cand_d;
         vis_cnt_q    <= vis_cnt_d;
         storm_flag_q <= storm_flag_d;
         storm_cnt_q  <= storm_cnt_d;
         wind_q       <= wind_d;
         vis_q        <= vis_d;
         temp_q       <= temp_d;
         thunder_q    <= thunder_d;
         data_valid_q <= data_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign wind         = wind_q;
   assign visibility   = vis_q;
   assign temperature  = temp_q;
   assign thunderstorm = thunder_q;
   assign data_valid   = data_valid_q;
   assign sensor_fault = fault_q;

endmodule

// File: tb/tb_env_sensor_conditioner.sv
module tb_env_sensor_conditioner;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       sample_valid = 1'b0;
   logic [5:0] raw_wind = '0;
   logic [1:0] raw_visibility = '0;
   logic [7:0] raw_temperature = '0;
   logic       raw_lightning = 1'b0;
   logic [5:0] wind;
   logic [1:0] visibility;
   logic [7:0] temperature;
   logic       thunderstorm;
   logic       data_valid;
   logic       sensor_fault;

   int n_checks = 0;
   int n_errors = 0;

   env_sensor_conditioner #(
      .TIMEOUT    (100),
      .STORM_HOLD (8),
      .VIS_STABLE (3)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .sample_valid    (sample_valid),
      .raw_wind        (raw_wind),
      .raw_visibility  (raw_visibility),
      .raw_temperature (raw_temperature),
      .raw_lightning   (raw_lightning),
      .wind            (wind),
      .visibility      (visibility),
      .temperature     (temperature),
      .thunderstorm    (thunderstorm),
      .data_valid      (data_valid),
      .sensor_fault    (sensor_fault)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with outputs updated.
   task automatic send(input int w, input int v, input int t, input logic l);
      raw_wind        = 6'(w);
      raw_visibility  = 2'(v);
      raw_temperature = 8'(t);
      raw_lightning   = l;
      sample_valid    = 1'b1;
      @(negedge CLK);
      sample_valid    = 1'b0;
      raw_lightning   = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   int vis_seq [7] = '{0, 3, 3, 0, 3, 3, 3};
   int vis_exp [7] = '{0, 0, 0, 0, 0, 0, 3};
   int wind_exp [4] = '{10, 12, 14, 16};

   initial begin
      @(negedge CLK);
      do_reset();
      check_eq("rst_wind", wind, 0);
      check_eq("rst_vis", visibility, 0);
      check_eq("rst_temp", $signed(temperature), 0);
      check_eq("rst_storm", thunderstorm, 0);
      check_eq("rst_dv", data_valid, 0);
      check_eq("rst_fault", sensor_fault, 0);

      // First sample primes the averages.
      send(12, 1, -20, 1'b0);
      check_eq("prime_wind", wind, 12);
      check_eq("prime_temp", $signed(temperature), -20);
      check_eq("prime_vis", visibility, 1);
      check_eq("prime_dv", data_valid, 1);
      @(negedge CLK);
      check_eq("dv_pulse_end", data_valid, 0);
      check_eq("hold_wind", wind, 12);

      // Mid-run reset discards history; reprime with 8 then ramp.
      do_reset();
      check_eq("rst2_wind", wind, 0);
      send(8, 0, 0, 1'b0);
      check_eq("prime8_wind", wind, 8);
      for (int i = 0; i < 4; i++) begin
         send(16, 0, 0, 1'b0);
         check_eq($sformatf("avg_wind%0d", i), wind, wind_exp[i]);
      end

      // Visibility debounce after a prime of 0.
      do_reset();
      send(0, 0, 0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         send(0, vis_seq[i], 0, 1'b0);
         check_eq($sformatf("vis%0d", i), visibility, vis_exp[i]);
      end

      // Storm hold: one lightning then 8 clear samples.
      send(0, 3, 0, 1'b1);
      check_eq("storm_set", thunderstorm, 1);
      for (int i = 1; i <= 8; i++) begin
         send(0, 3, 0, 1'b0);
         check_eq($sformatf("storm_clear%0d", i), thunderstorm, (i < 8) ? 1 : 0);
      end

      // Back-to-back samples, none dropped.
      do_reset();
      send(0, 0, 0, 1'b0);
      raw_wind = 6'd4; sample_valid = 1'b1;
      @(negedge CLK);
      check_eq("b2b_wind0", wind, 1);
      check_eq("b2b_dv0", data_valid, 1);
      raw_wind = 6'd8;
      @(negedge CLK);
      sample_valid = 1'b0;
      check_eq("b2b_wind1", wind, 3);
      check_eq("b2b_dv1", data_valid, 1);

      // Timeout: 99 idle edges no fault, 100th faults.
      repeat (99) @(negedge CLK);
      check_eq("pre_fault", sensor_fault, 0);
      @(negedge CLK);
      check_eq("fault_set", sensor_fault, 1);
      check_eq("fault_storm", thunderstorm, 1);
      check_eq("fault_dv", data_valid, 0);
      check_eq("fault_hold_wind", wind, 3);
      send(5, 0, 0, 1'b0);
      check_eq("recover_fault", sensor_fault, 0);
      check_eq("recover_wind", wind, 5);
      check_eq("recover_storm", thunderstorm, 0);
      check_eq("recover_dv", data_valid, 1);

      // Negative averages with floor rounding.
      send(5, 0, -127, 1'b0);
      check_eq("temp_a", $signed(temperature), -32);
      send(5, 0, -128, 1'b0);
      send(5, 0, -128, 1'b0);
      check_eq("temp_b", $signed(temperature), -96);
      // Sample arrives on the edge the idle counter would hit TIMEOUT.
      repeat (99) @(negedge CLK);
      check_eq("pre_race_fault", sensor_fault, 0);
      send(5, 0, -128, 1'b0);
      check_eq("race_fault", sensor_fault, 0);
      check_eq("race_dv", data_valid, 1);
      check_eq("temp_min", $signed(temperature), -128);
      @(negedge CLK);
      check_eq("race_no_fault_after", sensor_fault, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
